// File: rtl/tow_scorer_n_if.sv
// -----------------------------------------------------------------------------
// tow_scorer_n_if
// Groups the push-arbiter inputs and the LED/score outputs of tow_scorer_n.
// The parameters must match those of the tow_scorer_n instance using it.
//
// Signals (direction as seen by the scorer, modport slave):
//   winrnd         in   one-cycle pulse: a push was arbitrated
//   right          in   1 = right player pushed first
//   tie            in   1 = simultaneous push (qualifies winrnd)
//   leds_on        in   1 = proper push, 0 = jump-the-light
//   hcap_l/hcap_r  in   double-step enables indexed by losing distance
//   score          out  LED word, 2*STEPS+2 bits
//   rounds_l/_r    out  rounds won per player
//   round_done     out  one-cycle pulse on a round win
//   match_over     out  sticky match-decided flag
//   match_winner_r out  1 = right player won the match
// -----------------------------------------------------------------------------
interface tow_scorer_n_if #(
  parameter int STEPS     = 3,
  parameter int MATCH_PTS = 3
);
  localparam int SW = 2*STEPS + 2;
  localparam int RW = $clog2(MATCH_PTS + 1);

  logic          winrnd;
  logic          right;
  logic          tie;
  logic          leds_on;
  logic [STEPS:0] hcap_l;
  logic [STEPS:0] hcap_r;
  logic [SW-1:0] score;
  logic [RW-1:0] rounds_l;
  logic [RW-1:0] rounds_r;
  logic          round_done;
  logic          match_over;
  logic          match_winner_r;

  // Push arbiter / bench side.
  modport master (
    output winrnd, right, tie, leds_on, hcap_l, hcap_r,
    input  score, rounds_l, rounds_r, round_done, match_over, match_winner_r
  );

  // Scorer side.
  modport slave (
    input  winrnd, right, tie, leds_on, hcap_l, hcap_r,
    output score, rounds_l, rounds_r, round_done, match_over, match_winner_r
  );
endinterface

// File: rtl/tow_scorer_n.sv
// -----------------------------------------------------------------------------
// tow_scorer_n
// Tug-of-war scorer: tracks the rope position on a symmetric track of STEPS
// positions per side, applies jump / proper-push / handicap rules, decodes the
// position onto the LED score word, counts rounds, holds each win for HOLD_CYC
// cycles before restarting, and declares a match winner after MATCH_PTS rounds.
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-low reset
//   bus  tow_scorer_n_if.slave (push inputs, score/round/match outputs)
//
// Parameters: STEPS (>=1), MATCH_PTS (>=1), HOLD_CYC (>=1).
// Optional feature: define TOW_SCORER_HCAP_EN to build the handicap latch and
// double-step logic; without it hcap_l/hcap_r are ignored and every move is
// a single step.
//
// Position encoding: signed pos, +k = Lk (left ahead), -k = Rk, 0 = N,
// +/-(STEPS+1) = WL / WR.
// -----------------------------------------------------------------------------
module tow_scorer_n #(
  parameter int STEPS     = 3,
  parameter int MATCH_PTS = 3,
  parameter int HOLD_CYC  = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  tow_scorer_n_if.slave bus
);

  localparam int SW  = 2*STEPS + 2;
  localparam int RW  = $clog2(MATCH_PTS + 1);
  localparam int WIN = STEPS + 1;
  localparam int PW  = $clog2(WIN + 1) + 1;            // signed, holds +/-WIN
  localparam int HW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic signed [PW-1:0] POS_WL = PW'(WIN);
  localparam logic signed [PW-1:0] POS_WR = PW'(-WIN);
  localparam logic signed [PW:0]   SAT_HI = (PW+1)'(WIN);
  localparam logic signed [PW:0]   SAT_LO = (PW+1)'(-WIN);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_HOLD  = 2'd1,
    S_MATCH = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;

  logic signed [PW-1:0]  r_pos;
  logic [HW-1:0]         r_hold_cnt;
  logic [RW-1:0]         r_rounds_l;
  logic [RW-1:0]         r_rounds_r;
  logic                  r_round_done;
  logic                  r_match_over;
  logic                  r_winner_r;

  logic                  w_move_en;
  logic                  w_hold_en;
  logic                  w_hold_done;
  logic                  w_mr;
  logic                  w_dbl;
  logic signed [PW:0]    w_pos_ext;
  logic signed [PW:0]    w_step;
  logic signed [PW:0]    w_sum;
  logic signed [PW-1:0]  w_pos_mv;
  logic                  w_win;
  logic                  w_win_r;
  logic                  w_match_win;
  logic [RW-1:0]         w_rounds_l_inc;
  logic [RW-1:0]         w_rounds_r_inc;
  logic [SW-1:0]         w_score;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_PLAY;
    else      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_PLAY:  if (w_win) w_state_nxt = w_match_win ? S_MATCH : S_HOLD;
      S_HOLD:  if (w_hold_done) w_state_nxt = S_PLAY;
      S_MATCH: w_state_nxt = S_MATCH;
      default: w_state_nxt = S_PLAY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  // Pushes only count in PLAY; a push landing on the last HOLD cycle is
  // dropped because the FSM is still in HOLD at that edge.
  always_comb begin
    w_move_en   = 1'b0;
    w_hold_en   = 1'b0;
    w_hold_done = 1'b0;
    unique case (r_state)
      S_PLAY:  w_move_en = bus.winrnd & ~bus.tie;
      S_HOLD: begin
        w_hold_en   = 1'b1;
        w_hold_done = (r_hold_cnt == HW'(HOLD_CYC - 1));
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Move direction and handicap
  // ---------------------------------------------------------------------------
  // mr = 1 means the rope moves towards the right player (pos decrements).
  // A jump hands the step to the opponent, hence the XNOR form.
  assign w_mr = (bus.right & bus.leds_on) | (~bus.right & ~bus.leds_on);

`ifdef TOW_SCORER_HCAP_EN
  logic [STEPS:0] r_hcap_l;
  logic [STEPS:0] r_hcap_r;
  logic           w_dbl_l;
  logic           w_dbl_r;

  // Handicap enables follow the inputs while the rope is centred and freeze
  // once play leaves N, so mid-round changes cannot alter the odds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hcap_l <= '0;
      r_hcap_r <= '0;
    end else if (r_pos == '0) begin
      r_hcap_l <= bus.hcap_l;
      r_hcap_r <= bus.hcap_r;
    end
  end

  // Losing distance lookup: right mover loses at pos>=0, left mover at pos<=0.
  // Positions on the mover's winning side match no entry and never double.
  always_comb begin
    w_dbl_l = 1'b0;
    w_dbl_r = 1'b0;
    for (int k = 0; k <= STEPS; k++) begin
      if (r_pos == PW'(k))  w_dbl_r = r_hcap_r[k];
      if (r_pos == PW'(-k)) w_dbl_l = r_hcap_l[k];
    end
  end

  // Only a proper push can earn the double step.
  assign w_dbl = bus.leds_on & (w_mr ? w_dbl_r : w_dbl_l);
`else
  logic w_unused_hcap;
  assign w_unused_hcap = ^{bus.hcap_l, bus.hcap_r};
  assign w_dbl         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next position with saturation at the win positions
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pos_ext = {r_pos[PW-1], r_pos};
    w_step    = w_dbl ? (PW+1)'(2) : (PW+1)'(1);
    w_sum     = w_mr ? (w_pos_ext - w_step) : (w_pos_ext + w_step);
    if (w_sum > SAT_HI)      w_pos_mv = POS_WL;
    else if (w_sum < SAT_LO) w_pos_mv = POS_WR;
    else                     w_pos_mv = w_sum[PW-1:0];
  end

  assign w_win          = w_move_en & ((w_pos_mv == POS_WL) | (w_pos_mv == POS_WR));
  assign w_win_r        = (w_pos_mv == POS_WR);
  assign w_rounds_l_inc = r_rounds_l + RW'(1);
  assign w_rounds_r_inc = r_rounds_r + RW'(1);
  assign w_match_win    = w_win & (w_win_r ? (w_rounds_r_inc == RW'(MATCH_PTS))
                                           : (w_rounds_l_inc == RW'(MATCH_PTS)));

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is reset, including counters and flags, so a
  // reset in HOLD or MATCH returns the block to a clean PLAY state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pos        <= '0;
      r_hold_cnt   <= '0;
      r_rounds_l   <= '0;
      r_rounds_r   <= '0;
      r_round_done <= 1'b0;
      r_match_over <= 1'b0;
      r_winner_r   <= 1'b0;
    end else begin
      r_round_done <= w_win;

      if (w_move_en)        r_pos <= w_pos_mv;
      else if (w_hold_done) r_pos <= '0;

      // Counter idles at zero so each HOLD starts from a clean count.
      if (w_hold_en && !w_hold_done) r_hold_cnt <= r_hold_cnt + HW'(1);
      else                           r_hold_cnt <= '0;

      if (w_win &&  w_win_r) r_rounds_r <= w_rounds_r_inc;
      if (w_win && !w_win_r) r_rounds_l <= w_rounds_l_inc;

      if (w_match_win) begin
        r_match_over <= 1'b1;
        r_winner_r   <= w_win_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Score decode
  // ---------------------------------------------------------------------------
  // N lights the two centre LEDs; a win lights the whole winner's half.
  always_comb begin
    w_score = '0;
    if (r_pos == '0) begin
      w_score[STEPS+1] = 1'b1;
      w_score[STEPS]   = 1'b1;
    end else if (r_pos == POS_WL) begin
      for (int b = STEPS + 2; b < SW; b++) w_score[b] = 1'b1;
    end else if (r_pos == POS_WR) begin
      for (int b = 0; b < STEPS; b++) w_score[b] = 1'b1;
    end else begin
      for (int k = 1; k <= STEPS; k++) begin
        if (r_pos == PW'(k))  w_score[STEPS+1+k] = 1'b1;
        if (r_pos == PW'(-k)) w_score[STEPS-k]   = 1'b1;
      end
    end
  end

  assign bus.score          = w_score;
  assign bus.rounds_l       = r_rounds_l;
  assign bus.rounds_r       = r_rounds_r;
  assign bus.round_done     = r_round_done;
  assign bus.match_over     = r_match_over;
  assign bus.match_winner_r = r_winner_r;

endmodule

// File: tb/tb_tow_scorer_n.sv
// -----------------------------------------------------------------------------
// tb_tow_scorer_n
// Directed bench for tow_scorer_n with STEPS=3, MATCH_PTS=2, HOLD_CYC=4.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge. Expected values are hand-computed LED words.
// Handicap expectations follow whether TOW_SCORER_HCAP_EN is defined.
// -----------------------------------------------------------------------------
module tb_tow_scorer_n;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  tow_scorer_n_if #(.STEPS(3), .MATCH_PTS(2)) bus_if ();

  tow_scorer_n #(
    .STEPS     (3),
    .MATCH_PTS (2),
    .HOLD_CYC  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait one rising edge and return at the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle arbitrated push.
  task automatic push(input logic r, input logic l, input logic t);
    bus_if.right   = r;
    bus_if.leds_on = l;
    bus_if.tie     = t;
    bus_if.winrnd  = 1'b1;
    @(negedge clk);
    bus_if.winrnd  = 1'b0;
    bus_if.tie     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_score"}, 32'(bus_if.score), 32'h18);
    check({tag, "_rl"},    32'(bus_if.rounds_l), 32'd0);
    check({tag, "_rr"},    32'(bus_if.rounds_r), 32'd0);
    check({tag, "_rd"},    32'(bus_if.round_done), 32'd0);
    check({tag, "_mo"},    32'(bus_if.match_over), 32'd0);
    check({tag, "_mw"},    32'(bus_if.match_winner_r), 32'd0);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    rst            = 1'b0;
    bus_if.winrnd  = 1'b0;
    bus_if.right   = 1'b0;
    bus_if.tie     = 1'b0;
    bus_if.leds_on = 1'b0;
    bus_if.hcap_l  = '0;
    bus_if.hcap_r  = '0;

    // Reset state.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;

    // Four proper right pushes walk R1, R2, R3, WR.
    push(1'b1, 1'b1, 1'b0);
    check("r1_score", 32'(bus_if.score), 32'h04);
    check("r1_rd",    32'(bus_if.round_done), 32'd0);
    push(1'b1, 1'b1, 1'b0);
    check("r2_score", 32'(bus_if.score), 32'h02);
    push(1'b1, 1'b1, 1'b0);
    check("r3_score", 32'(bus_if.score), 32'h01);
    check("r3_rd",    32'(bus_if.round_done), 32'd0);
    push(1'b1, 1'b1, 1'b0);
    check("wr_score", 32'(bus_if.score), 32'h07);
    check("wr_rd",    32'(bus_if.round_done), 32'd1);
    check("wr_rr",    32'(bus_if.rounds_r), 32'd1);
    check("wr_mo",    32'(bus_if.match_over), 32'd0);

    // HOLD: a push is ignored and round_done drops after one cycle.
    push(1'b0, 1'b1, 1'b0);
    check("hold1_score", 32'(bus_if.score), 32'h07);
    check("hold1_rd",    32'(bus_if.round_done), 32'd0);
    tick();
    tick();
    check("hold3_score", 32'(bus_if.score), 32'h07);
    // Push on the HOLD->PLAY edge is dropped; N reappears.
    push(0, 1'b1, 1'b0);
    check("restart_score", 32'(bus_if.score), 32'h18);
    check("restart_rr",    32'(bus_if.rounds_r), 32'd1);
    check("restart_rl",    32'(bus_if.rounds_l), 32'd0);

    // Right jump helps the left player; a tie changes nothing.
    push(1'b1, 1'b0, 1'b0);
    check("jump_score", 32'(bus_if.score), 32'h20);
    push(1'b1, 1'b0, 1'b1);
    check("tie_score",  32'(bus_if.score), 32'h20);
    push(1'b0, 1'b0, 1'b0);
    check("ljump_score", 32'(bus_if.score), 32'h18);

    // Handicap for right player from N; frozen once off-centre.
    bus_if.hcap_r = 4'b0001;
    tick();
    push(1'b1, 1'b1, 1'b0);
`ifdef TOW_SCORER_HCAP_EN
    check("hcap_dbl_score", 32'(bus_if.score), 32'h02);
`else
    check("hcap_dbl_score", 32'(bus_if.score), 32'h04);
`endif
    bus_if.hcap_r = 4'b1111;
    push(1'b1, 1'b1, 1'b0);
`ifdef TOW_SCORER_HCAP_EN
    check("hcap_win_side_score", 32'(bus_if.score), 32'h01);
`else
    check("hcap_win_side_score", 32'(bus_if.score), 32'h02);
    push(1'b1, 1'b1, 1'b0);
    check("nohcap_r3_score", 32'(bus_if.score), 32'h01);
`endif
    bus_if.hcap_r = '0;

    // Second right round decides the match.
    push(1'b1, 1'b1, 1'b0);
    check("match_score", 32'(bus_if.score), 32'h07);
    check("match_rd",    32'(bus_if.round_done), 32'd1);
    check("match_rr",    32'(bus_if.rounds_r), 32'd2);
    check("match_mo",    32'(bus_if.match_over), 32'd1);
    check("match_mw",    32'(bus_if.match_winner_r), 32'd1);

    // MATCH is terminal: pushes of every kind are ignored.
    for (int i = 0; i < 12; i++) begin
      push(i[0], ~i[0], 1'b0);
    end
    check("frozen_score", 32'(bus_if.score), 32'h07);
    check("frozen_mo",    32'(bus_if.match_over), 32'd1);
    check("frozen_mw",    32'(bus_if.match_winner_r), 32'd1);
    check("frozen_rd",    32'(bus_if.round_done), 32'd0);
    check("frozen_rl",    32'(bus_if.rounds_l), 32'd0);

    // Reset out of MATCH.
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_match");
    rst = 1'b1;

    // Left round win, then reset during HOLD cycle 2.
    push(1'b0, 1'b1, 1'b0);
    check("l1_score", 32'(bus_if.score), 32'h20);
    push(1'b0, 1'b1, 1'b0);
    check("l2_score", 32'(bus_if.score), 32'h40);
    push(1'b0, 1'b1, 1'b0);
    check("l3_score", 32'(bus_if.score), 32'h80);
    push(1'b0, 1'b1, 1'b0);
    check("wl_score", 32'(bus_if.score), 32'hE0);
    check("wl_rl",    32'(bus_if.rounds_l), 32'd1);
    check("wl_rd",    32'(bus_if.round_done), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_hold");
    rst = 1'b1;

    // Handicap for left player from N.
    bus_if.hcap_l = 4'b0001;
    tick();
    push(1'b0, 1'b1, 1'b0);
`ifdef TOW_SCORER_HCAP_EN
    check("hcap_l_score", 32'(bus_if.score), 32'h40);
`else
    check("hcap_l_score", 32'(bus_if.score), 32'h20);
`endif
    bus_if.hcap_l = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
